// File: rtl/dpram_multilane.sv
// dpram_multilane: dual-port byte-lane RAM with one LANES-wide read port and one
// variable-size (1..LANES bytes) write port. Both ports wrap addresses at ADDR_LINE.
// Reads forward bytes written on the same edge (write-first, per byte). Writes at or
// beyond ADDR_LINE are dropped and flagged with a one-cycle err_b pulse.
// Optional feature macro: DPRAM_OUT_REG_EN adds a second output register stage
// (read latency 2 instead of 1). Memory contents are never reset.
module dpram_multilane #(
  parameter int ADDR_WIDTH = 19,
  parameter int ADDR_LINE  = 519168,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 16,
  parameter int SIZE_WIDTH = 5
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             re_a,
  input  logic [ADDR_WIDTH-1:0]            addr_a,
  output logic [DATA_WIDTH*LANES-1:0]      dout_a,
  output logic                             valid_a,
  input  logic                             we_b,
  input  logic [ADDR_WIDTH-1:0]            addr_b,
  input  logic [SIZE_WIDTH-1:0]            size_b,
  input  logic [DATA_WIDTH*LANES-1:0]      din_b,
  output logic                             err_b
);

  localparam int INOUT_WIDTH = DATA_WIDTH * LANES;
  localparam int IDX_WIDTH   = (ADDR_LINE > 1) ? $clog2(ADDR_LINE) : 1;
  localparam logic [ADDR_WIDTH:0]   LINE_EXT = (ADDR_WIDTH + 1)'(ADDR_LINE);
  localparam logic [SIZE_WIDTH-1:0] LANES_SZ = SIZE_WIDTH'(LANES);

  logic [DATA_WIDTH-1:0]  mem [ADDR_LINE];

  logic [IDX_WIDTH-1:0]   rd_idx [LANES];
  logic [IDX_WIDTH-1:0]   wr_idx [LANES];
  logic                   rd_oor;
  logic                   wr_ok;
  logic [SIZE_WIDTH-1:0]  wr_n;
  logic [LANES-1:0]       wr_en;
  logic [INOUT_WIDTH-1:0] rd_data;

  logic [INOUT_WIDTH-1:0] dout_q;
  logic                   valid_q;
  logic                   err_q;

  // Per-lane wrapped addresses for both ports; base < ADDR_LINE needs at most one wrap.
  always_comb begin
    logic [ADDR_WIDTH:0] rsum;
    logic [ADDR_WIDTH:0] wsum;
    rsum = '0;
    wsum = '0;
    for (int i = 0; i < LANES; i++) begin
      rsum = {1'b0, addr_a} + (ADDR_WIDTH + 1)'(i);
      wsum = {1'b0, addr_b} + (ADDR_WIDTH + 1)'(i);
      if (rsum >= LINE_EXT) rsum = rsum - LINE_EXT;
      if (wsum >= LINE_EXT) wsum = wsum - LINE_EXT;
      rd_idx[i] = rsum[IDX_WIDTH-1:0];
      wr_idx[i] = wsum[IDX_WIDTH-1:0];
    end
  end

  // Write lane enables: size 0 or oversize means a full-width write; reset blocks writes.
  always_comb begin
    rd_oor = ({1'b0, addr_a} >= LINE_EXT);
    wr_ok  = ({1'b0, addr_b} <  LINE_EXT);
    wr_n   = ((size_b == '0) || (size_b > LANES_SZ)) ? LANES_SZ : size_b;
    wr_en  = '0;
    for (int i = 0; i < LANES; i++) begin
      wr_en[i] = we_b && !rst && wr_ok && (SIZE_WIDTH'(i) < wr_n);
    end
  end

  // Read data with per-byte write-first forwarding on wrapped addresses.
  always_comb begin
    logic [DATA_WIDTH-1:0] lane;
    lane    = '0;
    rd_data = '0;
    for (int i = 0; i < LANES; i++) begin
      lane = mem[rd_idx[i]];
      for (int j = 0; j < LANES; j++) begin
        if (wr_en[j] && (wr_idx[j] == rd_idx[i])) lane = din_b[j*DATA_WIDTH +: DATA_WIDTH];
      end
      rd_data[i*DATA_WIDTH +: DATA_WIDTH] = lane;
    end
    // Out-of-range base reads return zero but still count as accepted.
    if (rd_oor) rd_data = '0;
  end

  // Memory array update, enabled lanes only; no reset on contents.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) mem[wr_idx[i]] <= din_b[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // First output stage plus the rejected-write pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= re_a ? rd_data : '0;
      valid_q <= re_a;
      err_q   <= we_b && !wr_ok;
    end
  end

  assign err_b = err_q;

`ifdef DPRAM_OUT_REG_EN
  logic [INOUT_WIDTH-1:0] dout_q2;
  logic                   valid_q2;

  // Second output stage: delays data and valid together, keeps full throughput.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q2  <= '0;
      valid_q2 <= 1'b0;
    end else begin
      dout_q2  <= dout_q;
      valid_q2 <= valid_q;
    end
  end

  assign dout_a  = dout_q2;
  assign valid_a = valid_q2;
`else
  assign dout_a  = dout_q;
  assign valid_a = valid_q;
`endif

endmodule

// File: tb/tb_dpram_multilane.sv
// tb_dpram_multilane: directed, self-checking bench for dpram_multilane with a reduced
// memory (ADDR_LINE=1000). A byte-array model tracks every write the bench issues.
module tb_dpram_multilane;

  localparam int AW   = 10;
  localparam int LINE = 1000;
  localparam int NL   = 16;
`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          re_a;
  logic [AW-1:0] addr_a;
  logic [127:0]  dout_a;
  logic          valid_a;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [4:0]    size_b;
  logic [127:0]  din_b;
  logic          err_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] model [LINE];

  dpram_multilane #(
    .ADDR_WIDTH(AW),
    .ADDR_LINE (LINE),
    .DATA_WIDTH(8),
    .LANES     (NL),
    .SIZE_WIDTH(5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .re_a   (re_a),
    .addr_a (addr_a),
    .dout_a (dout_a),
    .valid_a(valid_a),
    .we_b   (we_b),
    .addr_b (addr_b),
    .size_b (size_b),
    .din_b  (din_b),
    .err_b  (err_b)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          re;
    logic [AW-1:0] ra;
    logic          we;
    logic [AW-1:0] wa;
    logic [4:0]    sz;
    logic [127:0]  din;
    logic          ev;
    logic          ee;
  } vec_t;

  function automatic logic [7:0] pre(int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  function automatic vec_t mk(logic re, int ra, logic we, int wa, int sz, logic [127:0] din,
                              logic ev, logic ee);
    vec_t v;
    v.re = re; v.ra = AW'(ra); v.we = we; v.wa = AW'(wa); v.sz = 5'(sz);
    v.din = din; v.ev = ev; v.ee = ee;
    return v;
  endfunction

  task automatic model_write(int wa, int sz, logic [127:0] din);
    int n;
    n = (sz == 0 || sz > NL) ? NL : sz;
    if (wa < LINE) begin
      for (int i = 0; i < n; i++) model[(wa + i) % LINE] = din[i*8 +: 8];
    end
  endtask

  function automatic logic [127:0] model_read(int ra);
    logic [127:0] r;
    r = '0;
    if (ra < LINE) begin
      for (int i = 0; i < NL; i++) r[i*8 +: 8] = model[(ra + i) % LINE];
    end
    return r;
  endfunction

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    re_a = 1'b0; we_b = 1'b0; addr_a = '0; addr_b = '0; size_b = '0; din_b = '0;
  endtask

  task automatic do_write(int wa, int sz, logic [127:0] din);
    we_b = 1'b1; addr_b = AW'(wa); size_b = 5'(sz); din_b = din;
    model_write(wa, sz, din);
    step();
    we_b = 1'b0;
  endtask

  // One read, outputs captured LAT edges after acceptance.
  task automatic do_read(int ra, output logic [127:0] d, output logic v);
    d = '0; v = 1'b0;
    re_a = 1'b1; addr_a = AW'(ra);
    for (int c = 1; c <= LAT; c++) begin
      step();
      re_a = 1'b0;
      if (c == LAT) begin d = dout_a; v = valid_a; end
    end
  endtask

  vec_t         vecs [12];
  logic [127:0] got_d;
  logic         got_v;
  logic         got_e;
  logic [127:0] exp_d;
  logic [15:0]  pat;
  logic [127:0] s_exp [16];

  initial begin
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Preload whole memory through the write port.
    for (int a = 0; a < LINE; a += NL) begin
      logic [127:0] d;
      for (int i = 0; i < NL; i++) d[i*8 +: 8] = pre((a + i) % LINE);
      do_write(a, 0, d);
    end

    // 1: reset with active requests.
    rst = 1'b1; re_a = 1'b1; addr_a = '0; we_b = 1'b1; addr_b = '0; size_b = '0;
    din_b = {128{1'b1}};
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("rst_dout_%0d", c), dout_a, '0);
      chk($sformatf("rst_valid_%0d", c), 128'(valid_a), 128'(1'b0));
      chk($sformatf("rst_err_%0d", c), 128'(err_b), 128'(1'b0));
    end
    rst = 1'b0;
    idle_inputs();
    do_read(0, got_d, got_v);
    chk("rst_mem_kept", got_d, model_read(0));

    // 2: partial write then read-back.
    do_write(100, 3, 128'hEEEEEEEEEEEEEEEEEEEEEEEEEECCBBAA);
    do_read(100, got_d, got_v);
    chk("t2_lanes0_3", 128'(got_d[31:0]), 128'({pre(103), 8'hCC, 8'hBB, 8'hAA}));
    chk("t2_full", got_d, model_read(100));
    chk("t2_valid", 128'(got_v), 128'(1'b1));
    do_write(100, 0, 128'h0F0E0D0C0B0A09080706050403020100);
    do_read(100, got_d, got_v);
    chk("t2_size0_all", got_d, 128'h0F0E0D0C0B0A09080706050403020100);

    // 3: same-edge write and read, partial overlap.
    we_b = 1'b1; addr_b = 10; size_b = 4; din_b = 128'h44332211;
    model_write(10, 4, 128'h44332211);
    re_a = 1'b1; addr_a = 8;
    for (int c = 1; c <= LAT; c++) begin
      step();
      idle_inputs();
      if (c == LAT) got_d = dout_a;
    end
    chk("t3_fwd_2_5", 128'(got_d[47:16]), 128'(32'h44332211));
    chk("t3_lanes0_1", 128'(got_d[15:0]), 128'({pre(9), pre(8)}));
    chk("t3_lanes6_15", 128'(got_d[127:48]), 128'(model_read(8) >> 48));

    // 4: write wrapping at the top of memory.
    do_write(LINE - 2, 4, 128'hD4D3D2D1);
    do_read(LINE - 2, got_d, got_v);
    chk("t4_wrap_0_3", 128'(got_d[31:0]), 128'(32'hD4D3D2D1));
    chk("t4_lane4", 128'(got_d[39:32]), 128'(pre(2)));

    // 5: rejected write and out-of-range read on the same edge.
    we_b = 1'b1; addr_b = AW'(LINE); size_b = 0; din_b = {128{1'b1}};
    re_a = 1'b1; addr_a = AW'(LINE);
    got_e = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      step();
      idle_inputs();
      if (c == 1) got_e = err_b;
      if (c == LAT) begin got_d = dout_a; got_v = valid_a; end
    end
    chk("t5_err_pulse", 128'(got_e), 128'(1'b1));
    chk("t5_err_one_cycle", 128'(err_b), 128'(1'b0));
    chk("t5_oor_dout", got_d, '0);
    chk("t5_oor_valid", 128'(got_v), 128'(1'b1));
    do_read(0, got_d, got_v);
    chk("t5_mem_kept", got_d, model_read(0));

    // Table of mixed single-edge vectors.
    vecs[0]  = mk(1, 100, 1, 100, 3, 128'h0102030405060708090A0B0C0D0E0F10, 1, 0);
    vecs[1]  = mk(1, 200, 1, 200, 0, 128'h112233445566778899AABBCCDDEEFF00, 1, 0);
    vecs[2]  = mk(1, 305, 1, 300, 16, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 1, 0);
    vecs[3]  = mk(1, 500, 1, 500, 17, 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF, 1, 0);
    vecs[4]  = mk(1, 995, 1, 990, 16, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF, 1, 0);
    vecs[5]  = mk(0, 0, 1, 1023, 5, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 0, 1);
    vecs[6]  = mk(1, 1000, 0, 0, 0, 128'h0, 1, 0);
    vecs[7]  = mk(0, 5, 0, 0, 0, 128'h0, 0, 0);
    vecs[8]  = mk(1, 999, 0, 0, 0, 128'h0, 1, 0);
    vecs[9]  = mk(1, 0, 1, 996, 31, 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF, 1, 0);
    vecs[10] = mk(1, 20, 1, 1000, 2, 128'h5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A5A, 1, 1);
    vecs[11] = mk(1, 16, 1, 30, 1, 128'h77777777777777777777777777777799, 1, 0);

    for (int k = 0; k < 12; k++) begin
      re_a = vecs[k].re; addr_a = vecs[k].ra; we_b = vecs[k].we; addr_b = vecs[k].wa;
      size_b = vecs[k].sz; din_b = vecs[k].din;
      if (vecs[k].we) model_write(int'(vecs[k].wa), int'(vecs[k].sz), vecs[k].din);
      exp_d = vecs[k].re ? model_read(int'(vecs[k].ra)) : '0;
      got_e = 1'b0;
      for (int c = 1; c <= LAT; c++) begin
        step();
        idle_inputs();
        if (c == 1) got_e = err_b;
        if (c == LAT) begin got_d = dout_a; got_v = valid_a; end
      end
      chk($sformatf("vec%0d_dout", k), got_d, exp_d);
      chk($sformatf("vec%0d_valid", k), 128'(got_v), 128'(vecs[k].ev));
      chk($sformatf("vec%0d_err", k), 128'(got_e), 128'(vecs[k].ee));
    end

    // 6: back-to-back reads with re_a dropped mid-stream.
    pat = 16'b1111_0011_1011_1111;
    for (int k = 0; k < 16; k++) s_exp[k] = pat[k] ? model_read(16 * k + 3) : '0;
    for (int k = 0; k < 16 + LAT - 1; k++) begin
      int idx;
      if (k < 16) begin
        re_a = pat[k]; addr_a = AW'(16 * k + 3);
      end else begin
        re_a = 1'b0;
      end
      step();
      idx = k - (LAT - 1);
      if (idx >= 0) begin
        chk($sformatf("t6_valid_%0d", idx), 128'(valid_a), 128'(pat[idx]));
        chk($sformatf("t6_dout_%0d", idx), dout_a, s_exp[idx]);
      end
    end
    idle_inputs();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
